// File: rtl/param_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : param_register_bank
// Purpose  : Parametrised general-purpose register file. It has two
//            combinational read ports (A, B) and two write ports (D high
//            priority, E low priority). Optional features are same-cycle
//            write-to-read bypass and a hardwired-zero r0. A sequential
//            bulk-clear engine zeroes one register per cycle while
//            clr_busy is high.
// Ports    : clk, rst_n (async, active-low)
//            ri_a/a, ri_b/b       - read index / read data, ports A and B
//            ri_d/d/rw            - write index / data / enable, port D
//            ri_e/e/we            - write index / data / enable, port E
//            clr_req              - bulk-clear request (sampled on clk rise)
//            clr_busy             - high while the bulk clear runs
// Revision : 1.0 - initial release, successor to fixed 8x8 register_bank
// ============================================================================
module param_register_bank #(
    parameter int WIDTH   = 8,
    parameter int NREGS   = 8,
    parameter int AW      = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ri_a,
    input  logic [AW-1:0]    ri_b,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    ri_d,
    input  logic [WIDTH-1:0] d,
    input  logic             rw,
    input  logic [AW-1:0]    ri_e,
    input  logic [WIDTH-1:0] e,
    input  logic             we,
    input  logic             clr_req,
    output logic             clr_busy
);

    localparam logic [0:0]    c_IDLE  = 1'b0;
    localparam logic [0:0]    c_CLEAR = 1'b1;
    // One extra bit so NREGS = 2^AW is representable.
    localparam logic [AW:0]   c_NREGS = (AW+1)'(NREGS);
    localparam logic [AW-1:0] c_LAST  = AW'(NREGS - 1);

    logic [WIDTH-1:0] r_mem [NREGS];
    logic [0:0]       r_state;
    logic [AW-1:0]    r_cnt;

    logic             w_idle;
    logic             w_wr_d;
    logic             w_wr_e;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // An index addresses real, writable storage: inside the file and not
    // the hardwired-zero r0. The same test governs reads returning zero.
    function automatic logic f_writable(input logic [AW-1:0] idx);
        f_writable = ({1'b0, idx} < c_NREGS) && !((ZERO_R0 != 0) && (idx == '0));
    endfunction

    // Compare-based mux keeps the lookup well defined when NREGS is not a
    // power of two (indexes past the end simply match nothing).
    function automatic logic [WIDTH-1:0] f_stored(input logic [AW-1:0] idx);
        f_stored = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == AW'(i)) begin
                f_stored = r_mem[i];
            end
        end
    endfunction

    function automatic logic [WIDTH-1:0] f_read(input logic [AW-1:0] idx);
        if (!f_writable(idx)) begin
            f_read = '0;
        end else if ((BYPASS != 0) && w_wr_d && (ri_d == idx)) begin
            f_read = d;
        end else if ((BYPASS != 0) && w_wr_e && (ri_e == idx)) begin
            f_read = e;
        end else begin
            f_read = f_stored(idx);
        end
    endfunction

    assign w_idle = (r_state == c_IDLE);

    // User writes (and therefore bypass) only exist while idle and out of
    // reset. Port E is dropped when port D targets the same register.
    assign w_wr_d = rst_n && w_idle && rw && f_writable(ri_d);
    assign w_wr_e = rst_n && w_idle && we && f_writable(ri_e)
                    && !(w_wr_d && (ri_e == ri_d));

    always_comb begin
        w_a = '0;
        w_b = '0;
        // Storage is forced to zero during reset, but bypass inputs are not,
        // so the read data is gated explicitly.
        if (rst_n) begin
            w_a = f_read(ri_a);
            w_b = f_read(ri_b);
        end
    end

    assign a        = w_a;
    assign b        = w_b;
    assign clr_busy = (r_state == c_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else if (r_state == c_IDLE) begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_d && (ri_d == AW'(i))) begin
                    r_mem[i] <= d;
                end else if (w_wr_e && (ri_e == AW'(i))) begin
                    r_mem[i] <= e;
                end
            end
            // Writes on the request edge still land; clearing starts next edge.
            if (clr_req) begin
                r_state <= c_CLEAR;
                r_cnt   <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (r_cnt == AW'(i)) begin
                    r_mem[i] <= '0;
                end
            end
            if (r_cnt == c_LAST) begin
                r_state <= c_IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_register_bank
// Purpose  : Directed self-checking bench for param_register_bank. Four
//            instances share one stimulus: defaults, BYPASS=0, ZERO_R0=1
//            and NREGS=6.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_register_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ri_a, ri_b, ri_d, ri_e;
    logic [7:0] d, e;
    logic       rw, we, clr_req;

    logic [7:0] a0, b0, a1, b1, a2, b2, a3, b3;
    logic       busy0, busy1, busy2, busy3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_register_bank u_def (
        .clk(clk), .rst_n(rst_n), .ri_a(ri_a), .ri_b(ri_b), .a(a0), .b(b0),
        .ri_d(ri_d), .d(d), .rw(rw), .ri_e(ri_e), .e(e), .we(we),
        .clr_req(clr_req), .clr_busy(busy0)
    );

    param_register_bank #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .ri_a(ri_a), .ri_b(ri_b), .a(a1), .b(b1),
        .ri_d(ri_d), .d(d), .rw(rw), .ri_e(ri_e), .e(e), .we(we),
        .clr_req(clr_req), .clr_busy(busy1)
    );

    param_register_bank #(.ZERO_R0(1)) u_zero (
        .clk(clk), .rst_n(rst_n), .ri_a(ri_a), .ri_b(ri_b), .a(a2), .b(b2),
        .ri_d(ri_d), .d(d), .rw(rw), .ri_e(ri_e), .e(e), .we(we),
        .clr_req(clr_req), .clr_busy(busy2)
    );

    param_register_bank #(.NREGS(6)) u_six (
        .clk(clk), .rst_n(rst_n), .ri_a(ri_a), .ri_b(ri_b), .a(a3), .b(b3),
        .ri_d(ri_d), .d(d), .rw(rw), .ri_e(ri_e), .e(e), .we(we),
        .clr_req(clr_req), .clr_busy(busy3)
    );

    // Advance past one rising edge; inputs are then driven mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rw = 1'b0; we = 1'b0; clr_req = 1'b0;
        ri_a = '0; ri_b = '0; ri_d = '0; ri_e = '0; d = '0; e = '0;
        #3;
        // Bypass stimulus present while in reset must not reach the outputs.
        rw = 1'b1; ri_d = 3'd3; d = 8'h5A; ri_a = 3'd3; ri_b = 3'd3;
        #1;
        n_tests++;
        if (a0 !== 8'h00 || b0 !== 8'h00) begin
            n_fail++; $display("FAIL reset_read: got a=%h b=%h expected 00/00", a0, b0);
        end
        n_tests++;
        if ({busy0, busy1, busy2, busy3} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0000", {busy0, busy1, busy2, busy3});
        end
        @(negedge clk);
        rst_n = 1'b1;
        rw = 1'b0;
        #1;
        n_tests++;
        if (a0 !== 8'h00) begin
            n_fail++; $display("FAIL reset_stored: got %h expected 00", a0);
        end
    endtask

    task automatic test_basic();
        tick();
        rw = 1'b1; ri_d = 3'd3; d = 8'h5A;
        tick();
        ri_d = 3'd7; d = 8'hC3;
        tick();
        rw = 1'b0; ri_a = 3'd3; ri_b = 3'd7;
        #1;
        n_tests++;
        if (a0 !== 8'h5A || b0 !== 8'hC3) begin
            n_fail++; $display("FAIL basic_rw: got a=%h b=%h expected 5a/c3", a0, b0);
        end
        n_tests++;
        if (a1 !== 8'h5A || b1 !== 8'hC3) begin
            n_fail++; $display("FAIL basic_nobyp: got a=%h b=%h expected 5a/c3", a1, b1);
        end
        // NREGS=6: r3 written, index 7 out of range.
        n_tests++;
        if (a3 !== 8'h5A || b3 !== 8'h00) begin
            n_fail++; $display("FAIL basic_six: got a=%h b=%h expected 5a/00", a3, b3);
        end
    endtask

    task automatic test_bypass_priority();
        we = 1'b1; ri_e = 3'd2; e = 8'h33;
        tick();
        rw = 1'b1; ri_d = 3'd2; d = 8'h11;
        we = 1'b1; ri_e = 3'd2; e = 8'h22;
        ri_a = 3'd2;
        #1;
        n_tests++;
        if (a0 !== 8'h11) begin
            n_fail++; $display("FAIL bypass_prio: got %h expected 11", a0);
        end
        n_tests++;
        if (a1 !== 8'h33) begin
            n_fail++; $display("FAIL nobypass_old: got %h expected 33", a1);
        end
        tick();
        rw = 1'b0; we = 1'b0;
        #1;
        n_tests++;
        if (a0 !== 8'h11 || a1 !== 8'h11) begin
            n_fail++; $display("FAIL prio_stored: got %h/%h expected 11/11", a0, a1);
        end
        // Different indexes write together; port E bypass also forwards.
        rw = 1'b1; ri_d = 3'd4; d = 8'h44;
        we = 1'b1; ri_e = 3'd5; e = 8'h55;
        ri_a = 3'd5; ri_b = 3'd4;
        #1;
        n_tests++;
        if (a0 !== 8'h55 || b0 !== 8'h44 || a1 !== 8'h00) begin
            n_fail++; $display("FAIL dual_bypass: got a0=%h b0=%h a1=%h expected 55/44/00", a0, b0, a1);
        end
        tick();
        rw = 1'b0; we = 1'b0;
        #1;
        n_tests++;
        if (a1 !== 8'h55 || b1 !== 8'h44) begin
            n_fail++; $display("FAIL dual_write: got a=%h b=%h expected 55/44", a1, b1);
        end
    endtask

    task automatic test_zero_r0();
        rw = 1'b1; ri_d = 3'd0; d = 8'hFF;
        we = 1'b1; ri_e = 3'd1; e = 8'h0F;
        ri_a = 3'd0; ri_b = 3'd1;
        #1;
        n_tests++;
        if (a2 !== 8'h00 || b2 !== 8'h0F || a0 !== 8'hFF) begin
            n_fail++; $display("FAIL zero_r0_pre: got a2=%h b2=%h a0=%h expected 00/0f/ff", a2, b2, a0);
        end
        tick();
        rw = 1'b0; we = 1'b0;
        #1;
        n_tests++;
        if (a2 !== 8'h00 || b2 !== 8'h0F || a0 !== 8'hFF || b0 !== 8'h0F) begin
            n_fail++; $display("FAIL zero_r0_post: got a2=%h b2=%h a0=%h b0=%h expected 00/0f/ff/0f", a2, b2, a0, b0);
        end
    endtask

    task automatic test_nregs6();
        logic [7:0] exp6 [6];
        exp6[0] = 8'hFF; exp6[1] = 8'h0F; exp6[2] = 8'h11;
        exp6[3] = 8'h5A; exp6[4] = 8'h44; exp6[5] = 8'h55;
        rw = 1'b1; ri_d = 3'd6; d = 8'hAA;
        ri_a = 3'd6; ri_b = 3'd7;
        #1;
        n_tests++;
        if (a3 !== 8'h00 || b3 !== 8'h00) begin
            n_fail++; $display("FAIL six_oob_pre: got a=%h b=%h expected 00/00", a3, b3);
        end
        tick();
        rw = 1'b0;
        #1;
        n_tests++;
        if (a3 !== 8'h00 || b3 !== 8'h00) begin
            n_fail++; $display("FAIL six_oob_post: got a=%h b=%h expected 00/00", a3, b3);
        end
        for (int j = 0; j < 3; j++) begin
            ri_a = 3'(2 * j); ri_b = 3'(2 * j + 1);
            #1;
            n_tests++;
            if (a3 !== exp6[2*j] || b3 !== exp6[2*j+1]) begin
                n_fail++; $display("FAIL six_contents[%0d]: got %h/%h expected %h/%h", j, a3, b3, exp6[2*j], exp6[2*j+1]);
            end
        end
        rw = 1'b1; ri_d = 3'd5; d = 8'hA5;
        tick();
        rw = 1'b0; ri_a = 3'd5;
        #1;
        n_tests++;
        if (a3 !== 8'hA5) begin
            n_fail++; $display("FAIL six_r5_write: got %h expected a5", a3);
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        for (int i = 0; i < 8; i++) begin
            rw = 1'b1; ri_d = 3'(i); d = 8'h10 + 8'(i);
            tick();
        end
        rw = 1'b0;
        clr_req = 1'b1;
        tick();                       // edge k
        clr_req = 1'b0;
        busy_cycles = busy0 ? 1 : 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 4) begin
                // After edge k+3: r0..r2 cleared, r3..r7 untouched.
                for (int j = 0; j < 4; j++) begin
                    ri_a = 3'(2 * j); ri_b = 3'(2 * j + 1);
                    #1;
                    n_tests++;
                    if (a0 !== ((2*j   < 3) ? 8'h00 : 8'h10 + 8'(2*j)) ||
                        b0 !== ((2*j+1 < 3) ? 8'h00 : 8'h10 + 8'(2*j+1))) begin
                        n_fail++; $display("FAIL clear_partial[%0d]: got %h/%h", j, a0, b0);
                    end
                end
                // Writes and a second request during busy are ignored; no bypass.
                rw = 1'b1; ri_d = 3'd7; d = 8'h99; ri_a = 3'd7;
                clr_req = 1'b1;
                #1;
                n_tests++;
                if (a0 !== 8'h17) begin
                    n_fail++; $display("FAIL clear_no_bypass: got %h expected 17", a0);
                end
            end
            tick();                   // edge k+c
            if (c == 4) begin
                rw = 1'b0; clr_req = 1'b0;
            end
            if (!busy0) break;
            busy_cycles++;
        end
        n_tests++;
        if (busy_cycles != 8) begin
            n_fail++; $display("FAIL clear_busy_len: got %0d expected 8", busy_cycles);
        end
        for (int j = 0; j < 4; j++) begin
            ri_a = 3'(2 * j); ri_b = 3'(2 * j + 1);
            #1;
            n_tests++;
            if (a0 !== 8'h00 || b0 !== 8'h00) begin
                n_fail++; $display("FAIL clear_done[%0d]: got %h/%h expected 00/00", j, a0, b0);
            end
        end
        // First write after the clear (edge k+9) is accepted.
        rw = 1'b1; ri_d = 3'd4; d = 8'h44;
        tick();
        rw = 1'b0; ri_a = 3'd4;
        #1;
        n_tests++;
        if (a0 !== 8'h44 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL clear_after_write: got %h busy=%b expected 44 busy=0", a0, busy0);
        end
    endtask

    task automatic test_reset_midclear();
        for (int i = 0; i < 8; i++) begin
            rw = 1'b1; ri_d = 3'(i); d = 8'h20 + 8'(i);
            tick();
        end
        rw = 1'b0;
        clr_req = 1'b1;
        tick();                       // edge k
        clr_req = 1'b0;
        tick();
        tick();                       // edge k+2
        #2;
        rst_n = 1'b0;
        ri_a = 3'd5;
        #1;
        n_tests++;
        if (busy0 !== 1'b0 || a0 !== 8'h00) begin
            n_fail++; $display("FAIL midclear_reset: got busy=%b a=%h expected 0/00", busy0, a0);
        end
        #1;
        // Release and issue a write for the very next edge.
        rst_n = 1'b1;
        rw = 1'b1; ri_d = 3'd4; d = 8'h44;
        tick();
        rw = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ri_a = 3'(2 * j); ri_b = 3'(2 * j + 1);
            #1;
            n_tests++;
            if (a0 !== ((2*j == 4) ? 8'h44 : 8'h00) || b0 !== 8'h00) begin
                n_fail++; $display("FAIL midclear_contents[%0d]: got %h/%h", j, a0, b0);
            end
        end
        n_tests++;
        if (busy0 !== 1'b0) begin
            n_fail++; $display("FAIL midclear_idle: got busy=%b expected 0", busy0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass_priority();
        test_zero_r0();
        test_nregs6();
        test_clear();
        test_reset_midclear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_register_bank.md
# param_register_bank

Parametrised general-purpose register file for the datapath, successor to the fixed 8×8 `register_bank`. It provides:
- configurable width and depth;
- two combinational read ports and two write ports with fixed priority;
- optional write-to-read bypass and optional hardwired-zero r0;
- a sequential bulk-clear engine that zeroes the file one register per cycle with a busy indication.

It sits between the decode stage (register indexes) and the ALU (operands a/b, result d).

## Interface
Parameters:
- WIDTH, 8, data width of each register
- NREGS, 8, number of registers (2..256, need not be a power of two)
- AW, 3, index width; must satisfy 2^AW >= NREGS
- BYPASS, 1, 1 = read ports forward same-cycle write data
- ZERO_R0, 0, 1 = r0 always reads 0 and ignores writes

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ri_a  input  AW  read index, port A
- ri_b  input  AW  read index, port B
- a  output  WIDTH  read data, port A (combinational)
- b  output  WIDTH  read data, port B (combinational)
- ri_d  input  AW  write index, port D (high priority)
- d  input  WIDTH  write data, port D
- rw  input  1  write enable, port D
- ri_e  input  AW  write index, port E (low priority)
- e  input  WIDTH  write data, port E
- we  input  1  write enable, port E
- clr_req  input  1  bulk-clear request, sampled on rising edge
- clr_busy  output  1  high while the bulk clear is in progress

## Operation
- Storage is NREGS × WIDTH registers.
- Reset (rst_n low, asynchronous) sets:
  - all registers to 0;
  - FSM to IDLE and clear counter to 0;
  - clr_busy to 0.
  - With a and b combinational, both read 0 for any index while in reset.
- Read, combinational, same rule per port:
  - index >= NREGS → 0;
  - ZERO_R0=1 and index 0 → 0;
  - BYPASS=1, FSM IDLE, rw=1 and ri_d==index (index legal and writable) → d;
  - otherwise the same bypass check against port E (we, ri_e, e);
  - otherwise the stored value.
- Write, at rising edge, IDLE only:
  - a port writes when its enable is 1, its index < NREGS, and the target is not r0 with ZERO_R0=1;
  - if both ports target the same index, port D wins and port E is dropped;
  - different indexes write in the same cycle.
- Bulk-clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on an edge with clr_req=1; counter ← 0. User writes on that same edge still take effect.
  - In CLEAR, each edge zeroes register[counter] and increments the counter.
  - CLEAR → IDLE on the edge that clears NREGS-1.
  - In CLEAR, rw/we are ignored (no write, no bypass) and clr_req is ignored. Reads return current contents, i.e. partially cleared.
  - clr_busy = (state == CLEAR), registered.
- rst_n low during CLEAR aborts the clear: FSM to IDLE, all registers to 0.

## Timing
- Read latency: 0 cycles (combinational from indexes, stored state and bypass inputs).
- Write latency: data is visible from storage after the next rising edge; with BYPASS=1 it is visible in the same cycle.
- Clear, with clr_req=1 sampled at edge k:
  - clr_busy rises after edge k;
  - register i is zeroed at edge k+1+i;
  - clr_busy falls after edge k+NREGS;
  - clr_busy is high for exactly NREGS cycles.
- The first write accepted after a clear is at edge k+NREGS+1.
- No handshake stalls: writes issued while clr_busy=1 are silently lost. The issuer must gate on clr_busy.

## Test plan
1. Defaults (8×8, BYPASS=1, ZERO_R0=0): write r3←0x5A, then r7←0xC3 on successive edges. Read ri_a=3, ri_b=7 → a=0x5A, b=0xC3. After reset all reads → 0x00.
2. Bypass and priority:
   - same cycle rw=1, ri_d=2, d=0x11 and we=1, ri_e=2, e=0x22 with ri_a=2 → a=0x11 before the edge; r2=0x11 after the edge (port E dropped);
   - with BYPASS=0 the same stimulus → a=old r2 before the edge.
3. ZERO_R0=1: write r0←0xFF → a reads 0 at ri_a=0 both before and after the edge. A simultaneous write of r1←0x0F via port E succeeds.
4. NREGS=6, AW=3:
   - write index 6←0xAA → no register changes;
   - reading index 6 or 7 → 0;
   - r5 remains writable.
5. Bulk clear:
   - fill r0..r7 with 0x10..0x17, pulse clr_req at edge k → clr_busy is high for 8 cycles;
   - after edge k+3, r0..r2=0 and r3..r7 unchanged;
   - rw=1 to r7←0x99 during busy is ignored, and r7=0 at the end;
   - a second clr_req during busy does not extend busy.
6. Reset mid-clear: assert rst_n=0 asynchronously at cycle k+2 of a clear → clr_busy=0 immediately and all reads → 0. After rst_n rises, a write r4←0x44 at the next edge succeeds.
